// File: rtl/mult_pipe_nlane.sv
// ---------------------------------------------------------------------------
// mult_pipe_nlane
//
// Three-stage pipelined, multi-lane signed fixed-point multiplier.
// Each lane computes A*B on Q(DWIDTH-FRAC).FRAC operands and returns a
// Q(DWIDTH-FRAC).FRAC result. The result is either truncated (floor) or
// rounded half up, chosen per transaction. Each lane reports overflow on
// its own.
//
// Optional feature macro: MULT_PIPE_NLANE_SAT_EN
//   defined   : an overflowing lane saturates to the max/min representable value
//   undefined : the result is always the low DWIDTH bits (wrap-around);
//               out_ovf still reports overflow
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   input transaction present
//   in_ready   out  block accepts input this cycle
//   round_mode in   0 = truncate, 1 = round half up (travels with its input)
//   a_in       in   operand A, lane i at [i*DWIDTH +: DWIDTH]
//   b_in       in   operand B, same packing
//   out_valid  out  result present
//   out_ready  in   downstream accepts result
//   out_data   out  results, same packing
//   out_ovf    out  per-lane overflow, bit i = lane i
//
// Pipeline stages:
//   S1 registers the operands and round_mode.
//   S2 registers the full 2*DWIDTH-bit product of each lane.
//   S3 registers the converted result and the overflow flags.
// ---------------------------------------------------------------------------
module mult_pipe_nlane #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      round_mode,
    input  logic [LANES*DWIDTH-1:0]   a_in,
    input  logic [LANES*DWIDTH-1:0]   b_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DWIDTH-1:0]   out_data,
    output logic [LANES-1:0]          out_ovf
);

    localparam int PW = 2 * DWIDTH;
    localparam int LW = LANES * DWIDTH;

    // The rounding constant 2^(FRAC-1), at full product width.
    localparam logic signed [PW-1:0] RND_HALF = PW'(1) << (FRAC - 1);

`ifdef MULT_PIPE_NLANE_SAT_EN
    localparam logic [DWIDTH-1:0] SAT_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] SAT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};
`endif

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipeline moves as one unit. adv is high when the output
    // register is empty or is being drained this cycle. in_ready equals adv.
    // When adv is low, every stage holds, bubbles included. While out_valid
    // is high, out_data and out_ovf stay unchanged until out_ready is high.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1
    logic          v1_q, v1_d;
    logic          rm1_q, rm1_d;
    logic [LW-1:0] a1_q, a1_d;
    logic [LW-1:0] b1_q, b1_d;

    // Stage 2
    logic                 v2_q, v2_d;
    logic                 rm2_q, rm2_d;
    logic signed [PW-1:0] p2_q [LANES];
    logic signed [PW-1:0] p2_d [LANES];

    // Stage 3
    logic             v3_q, v3_d;
    logic [LW-1:0]    data3_q, data3_d;
    logic [LANES-1:0] ovf3_q, ovf3_d;

    // Combinational lane math
    logic signed [PW-1:0] a_ext [LANES];
    logic signed [PW-1:0] b_ext [LANES];
    logic signed [PW-1:0] rnd_c [LANES];
    logic signed [PW-1:0] res_c [LANES];
    logic [LANES-1:0]     ovf_c;
    logic [LW-1:0]        conv_c;

    // S1: operand capture. Data registers load only with a real
    // transaction, so bubbles never overwrite the held result values.
    always_comb begin
        v1_d  = v1_q;
        rm1_d = rm1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        if (adv) begin
            v1_d = in_valid;
            if (in_valid) begin
                rm1_d = round_mode;
                a1_d  = a_in;
                b1_d  = b_in;
            end
        end
    end

    // S2: full-width signed product per lane. Both operands are sign-extended
    // to 2*DWIDTH bits, so the truncated product is exact.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_ext[i] = {{DWIDTH{a1_q[i*DWIDTH+DWIDTH-1]}}, a1_q[i*DWIDTH +: DWIDTH]};
            b_ext[i] = {{DWIDTH{b1_q[i*DWIDTH+DWIDTH-1]}}, b1_q[i*DWIDTH +: DWIDTH]};
        end
    end

    always_comb begin
        v2_d  = v2_q;
        rm2_d = rm2_q;
        for (int i = 0; i < LANES; i++) begin
            p2_d[i] = p2_q[i];
        end
        if (adv) begin
            v2_d = v1_q;
            if (v1_q) begin
                rm2_d = rm1_q;
                for (int i = 0; i < LANES; i++) begin
                    p2_d[i] = a_ext[i] * b_ext[i];
                end
            end
        end
    end

    // S3: rounding, rescaling and overflow detection. Adding 2^(FRAC-1) at
    // 2*DWIDTH width cannot wrap, because |P| <= 2^(2*DWIDTH-2).
    // R fits in DWIDTH signed bits exactly when bits [PW-1:DWIDTH-1] all match.
    always_comb begin
        ovf_c  = '0;
        conv_c = '0;
        for (int i = 0; i < LANES; i++) begin
            rnd_c[i] = p2_q[i];
            if (rm2_q) begin
                rnd_c[i] = p2_q[i] + RND_HALF;
            end
            res_c[i] = rnd_c[i] >>> FRAC;
            ovf_c[i] = !((&res_c[i][PW-1:DWIDTH-1]) || !(|res_c[i][PW-1:DWIDTH-1]));
            conv_c[i*DWIDTH +: DWIDTH] = res_c[i][DWIDTH-1:0];
`ifdef MULT_PIPE_NLANE_SAT_EN
            if (ovf_c[i]) begin
                conv_c[i*DWIDTH +: DWIDTH] = res_c[i][PW-1] ? SAT_MIN : SAT_MAX;
            end
`endif
        end
    end

    always_comb begin
        v3_d    = v3_q;
        data3_d = data3_q;
        ovf3_d  = ovf3_q;
        if (adv) begin
            v3_d = v2_q;
            if (v2_q) begin
                data3_d = conv_c;
                ovf3_d  = ovf_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            rm1_q   <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            v2_q    <= 1'b0;
            rm2_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                p2_q[i] <= '0;
            end
            v3_q    <= 1'b0;
            data3_q <= '0;
            ovf3_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            rm1_q   <= rm1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            v2_q    <= v2_d;
            rm2_q   <= rm2_d;
            for (int i = 0; i < LANES; i++) begin
                p2_q[i] <= p2_d[i];
            end
            v3_q    <= v3_d;
            data3_q <= data3_d;
            ovf3_q  <= ovf3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_data  = data3_q;
    assign out_ovf   = ovf3_q;

endmodule

// File: tb/tb_mult_pipe_nlane.sv
// ---------------------------------------------------------------------------
// tb_mult_pipe_nlane
//
// Directed testbench for mult_pipe_nlane with the default parameters
// (DWIDTH=32, FRAC=24, LANES=4). The expected values for overflowing lanes
// follow MULT_PIPE_NLANE_SAT_EN. Inputs change 1 time unit after the rising
// edge, and outputs are sampled in that same region.
// ---------------------------------------------------------------------------
module tb_mult_pipe_nlane;

    localparam int DW = 32;
    localparam int LN = 4;
    localparam int LW = DW * LN;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          round_mode;
    logic [LW-1:0] a_in;
    logic [LW-1:0] b_in;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_data;
    logic [LN-1:0] out_ovf;

    int checks = 0;
    int errors = 0;

    mult_pipe_nlane #(.DWIDTH(DW), .FRAC(24), .LANES(LN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .round_mode (round_mode),
        .a_in       (a_in),
        .b_in       (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: present a single transaction, then wait for its result with a
    // cycle budget. lat counts cycles from presentation to out_valid.
    task automatic send_one(input logic [LW-1:0] a, input logic [LW-1:0] b,
                            input logic rm, output logic [LW-1:0] d,
                            output logic [LN-1:0] o, output int lat);
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        a_in       = a;
        b_in       = b;
        round_mode = rm;
        step();
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        d = out_data;
        o = out_ovf;
        step();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        round_mode = 1'b0;
        a_in       = '0;
        b_in       = '0;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL reset_out_data got %h exp 0", out_data);
        end
        checks++;
        if (out_ovf !== '0) begin
            errors++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [LW-1:0] a, b, d;
        logic [LN-1:0] o;
        int lat;
        a = '0; b = '0;
        a[31:0] = 32'h0180_0000;
        b[31:0] = 32'h0200_0000;
        send_one(a, b, 1'b0, d, o, lat);
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL basic_latency got %0d exp 3", lat);
        end
        checks++;
        if (d !== {96'h0, 32'h0300_0000}) begin
            errors++; $display("FAIL basic_data got %h exp %h", d, {96'h0, 32'h0300_0000});
        end
        checks++;
        if (o !== 4'b0000) begin
            errors++; $display("FAIL basic_ovf got %b exp 0000", o);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] ta [4] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb [4] = '{32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000};
        logic        tm [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] te [4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [LW-1:0] a, b, d;
        logic [LN-1:0] o;
        int lat;
        for (int i = 0; i < 4; i++) begin
            a = '0; b = '0;
            a[31:0] = ta[i];
            b[31:0] = tb[i];
            send_one(a, b, tm[i], d, o, lat);
            checks++;
            if (d[31:0] !== te[i] || lat !== 3) begin
                errors++;
                $display("FAIL round_%0d got %h lat %0d exp %h lat 3", i, d[31:0], lat, te[i]);
            end
            checks++;
            if (o !== 4'b0000) begin
                errors++; $display("FAIL round_ovf_%0d got %b exp 0000", i, o);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ta [3] = '{32'h7F00_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb [3] = '{32'h0200_0000, 32'h8000_0000, 32'h0200_0000};
`ifdef MULT_PIPE_NLANE_SAT_EN
        logic [31:0] te [3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
`else
        logic [31:0] te [3] = '{32'hFE00_0000, 32'h0000_0000, 32'h0000_0000};
`endif
        logic [LW-1:0] a, b, d;
        logic [LN-1:0] o;
        int lat;
        for (int i = 0; i < 3; i++) begin
            a = '0; b = '0;
            a[31:0] = ta[i];
            b[31:0] = tb[i];
            send_one(a, b, 1'b0, d, o, lat);
            checks++;
            if (d[31:0] !== te[i] || lat !== 3) begin
                errors++;
                $display("FAIL ovf_data_%0d got %h lat %0d exp %h lat 3", i, d[31:0], lat, te[i]);
            end
            checks++;
            if (o !== 4'b0001) begin
                errors++; $display("FAIL ovf_flag_%0d got %b exp 0001", i, o);
            end
        end
    endtask

    task automatic test_lanes();
        logic [LW-1:0] a, b, d, e;
        logic [LN-1:0] o;
        int lat;
        // lane0 1.5*2.0, lane1 -1.0*0.25, lane2 127*2 (overflow), lane3 0.125*8.0
        a = {32'h0020_0000, 32'h7F00_0000, 32'hFF00_0000, 32'h0180_0000};
        b = {32'h0800_0000, 32'h0200_0000, 32'h0040_0000, 32'h0200_0000};
`ifdef MULT_PIPE_NLANE_SAT_EN
        e = {32'h0100_0000, 32'h7FFF_FFFF, 32'hFFC0_0000, 32'h0300_0000};
`else
        e = {32'h0100_0000, 32'hFE00_0000, 32'hFFC0_0000, 32'h0300_0000};
`endif
        send_one(a, b, 1'b1, d, o, lat);
        checks++;
        if (d !== e || lat !== 3) begin
            errors++; $display("FAIL lanes_data got %h lat %0d exp %h lat 3", d, lat, e);
        end
        checks++;
        if (o !== 4'b0100) begin
            errors++; $display("FAIL lanes_ovf got %b exp 0100", o);
        end
    endtask

    // Two inputs on consecutive cycles with different round modes.
    // The results must come back on consecutive cycles, each rounded by its own mode.
    task automatic test_back_to_back();
        logic [31:0] got [2];
        int          cyc [2];
        int          n;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        a_in       = '0;
        b_in       = '0;
        a_in[31:0] = 32'h0000_0001;
        b_in[31:0] = 32'h0080_0000;
        round_mode = 1'b1;
        step();
        round_mode = 1'b0;
        step();
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        n = 0;
        got = '{32'hDEAD_BEEF, 32'hDEAD_BEEF};
        cyc = '{0, 0};
        for (int c = 2; c < 14 && n < 2; c++) begin
            if (out_valid === 1'b1) begin
                got[n] = out_data[31:0];
                cyc[n] = c;
                n++;
            end
            step();
        end
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL b2b_count got %0d exp 2", n);
        end
        checks++;
        if (got[0] !== 32'h0000_0001 || got[1] !== 32'h0000_0000) begin
            errors++; $display("FAIL b2b_data got %h %h exp 00000001 00000000", got[0], got[1]);
        end
        checks++;
        if (cyc[0] !== 3 || cyc[1] !== 4) begin
            errors++; $display("FAIL b2b_timing got %0d %0d exp 3 4", cyc[0], cyc[1]);
        end
    endtask

    // Stream k<<24 * 1.0 for k=1..8 while out_ready follows the pattern 1,0,0,1.
    // The scoreboard queue holds the accepted transactions in order.
    task automatic test_backpressure();
        logic [31:0]   exp_q[$];
        logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic          prev_stall;
        logic [LW-1:0] prev_data;
        logic [LN-1:0] prev_ovf;
        logic [31:0]   e;
        int            k;
        int            rx;
        k = 1;
        rx = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_ovf = '0;
        for (int c = 0; c < 200 && rx < 8; c++) begin
            out_ready = pat[c % 4];
            if (k <= 8) begin
                in_valid   = 1'b1;
                a_in       = '0;
                b_in       = '0;
                a_in[31:0] = 32'(k) << 24;
                b_in[31:0] = 32'h0100_0000;
                round_mode = 1'b0;
            end else begin
                in_valid = 1'b0;
                a_in     = '0;
                b_in     = '0;
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_ovf !== prev_ovf) begin
                    errors++;
                    $display("FAIL bp_stall_hold cycle %0d got v=%b %h exp v=1 %h",
                             c, out_valid, out_data[31:0], prev_data[31:0]);
                end
            end
            checks++;
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready_stall cycle %0d got %b exp 0", c, in_ready);
                end
            end else if (in_ready !== 1'b1) begin
                errors++; $display("FAIL bp_in_ready_open cycle %0d got %b exp 1", c, in_ready);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_output got %h exp none", out_data[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data[31:0] !== e) begin
                        errors++; $display("FAIL bp_order got %h exp %h", out_data[31:0], e);
                    end
                end
                rx++;
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data  = out_data;
            prev_ovf   = out_ovf;
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                exp_q.push_back(32'(k) << 24);
                k++;
            end
            step();
        end
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;
        checks++;
        if (rx !== 8 || k !== 9 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_totals got rx=%0d sent=%0d left=%0d exp rx=8 sent=8 left=0",
                     rx, k - 1, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        round_mode = 1'b0;
        a_in       = '0;
        b_in       = '0;
        a_in[31:0] = 32'h0100_0000;
        b_in[31:0] = 32'h0100_0000;
        step();
        a_in[31:0] = 32'h0200_0000;
        step();
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== '0) begin
                errors++;
                $display("FAIL rstmid_quiet cycle %0d got v=%b d=%h o=%b exp v=0 d=0 o=0",
                         c, out_valid, out_data, out_ovf);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_lanes();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_pipe_nlane.md
Name: mult_pipe_nlane

Overview:
- Parametrised, pipelined successor to the single-lane combinational fixed-point multiplier.
- Multiplies LANES pairs of signed Q(DWIDTH-FRAC).FRAC operands in parallel.
- Per-transaction rounding mode; per-lane overflow detection.
- valid/ready handshake with full-pipeline backpressure; used by sigmoid and neuron datapaths where a registered, stallable multiplier is required.

Parameters:
- DWIDTH, 32, operand and result width in bits (signed two's complement)
- FRAC, 24, fractional bits of operands and result; 1 <= FRAC < DWIDTH
- LANES, 4, number of parallel multiplier lanes; >= 1

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block accepts input this cycle
- round_mode  input  1  0 = truncate (floor), 1 = round half up; sampled with input
- a_in  input  LANES*DWIDTH  operand A; lane i at [i*DWIDTH +: DWIDTH]
- b_in  input  LANES*DWIDTH  operand B; same packing
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_data  output  LANES*DWIDTH  results; same packing
- out_ovf  output  LANES  per-lane overflow flag, bit i = lane i

Behaviour:
- One clock domain (clk); reset synchronous, active-high (rst).
- Pipeline stages:
  - S1: register operands and round_mode.
  - S2: register full 2*DWIDTH-bit signed product per lane.
  - S3: register rounded/converted result, ovf, and valid.
- Each stage has a valid bit.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational).
- All stages shift together when adv = 1. When adv = 0, all stage registers hold, including bubbles; no bubble collapsing.
- Input accepted when in_valid && in_ready. S1 valid loads in_valid on adv.
- Latency: accepted input appears at out_valid exactly 3 cycles later if out_ready stays high. Throughput 1 transaction/cycle.
- Output transfer when out_valid && out_ready. out_data and out_ovf are stable while out_valid=1 and out_ready=0.
- Arithmetic per lane, with P = A*B (2*DWIDTH signed):
  - truncate: R = P >>> FRAC (arithmetic shift, floor toward -inf).
  - round: R = (P + 2^(FRAC-1)) >>> FRAC, computed at 2*DWIDTH width. Cannot overflow, since the maximum P is 2^(2*DWIDTH-2).
- Overflow: ovf = 1 if R > 2^(DWIDTH-1)-1 or R < -2^(DWIDTH-1); evaluated in both macro configurations.
- Result conversion depends on the optional feature (below).
- round_mode travels with its transaction; changing it mid-pipeline affects only later inputs.
- Reset: all stage valids 0, out_valid 0, out_data 0, out_ovf 0. in_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation: in-flight transactions are discarded and produce no output.
- Simultaneous input accept and output transfer in one cycle is legal and loses nothing.
- Lanes are independent; no cross-lane carry.

Optional Feature:
- Macro: MULT_PIPE_NLANE_SAT_EN.
- Defined: an overflowing lane outputs 2^(DWIDTH-1)-1 (positive overflow) or -2^(DWIDTH-1) (negative overflow). Otherwise it outputs R[DWIDTH-1:0].
- Undefined: output is always R[DWIDTH-1:0] (wrap-around, matching the legacy bit-slice behaviour); out_ovf still reports overflow.

Test Plan (DWIDTH=32, FRAC=24, LANES=4 unless noted):
1. Basic: lane0 A=0x01800000 (1.5), B=0x02000000 (2.0), round_mode=0, out_ready=1 -> 3 cycles later out_valid=1, lane0=0x03000000, ovf=0.
2. Rounding: A=0x00000001, B=0x00800000, round_mode=0 -> 0x00000000; round_mode=1 -> 0x00000001. A=0xFFFFFFFF, B=0x00800000: mode 0 -> 0xFFFFFFFF; mode 1 -> 0x00000000.
3. Overflow:
   - A=0x7F000000, B=0x02000000 -> SAT_EN: 0x7FFFFFFF, ovf=1; no SAT_EN: 0xFE000000, ovf=1.
   - A=0x80000000, B=0x80000000 -> SAT_EN: 0x7FFFFFFF, ovf=1.
   - A=0x80000000, B=0x02000000 -> SAT_EN: 0x80000000, ovf=1.
4. Backpressure: stream 8 transactions (lane0 A=k<<24, B=0x01000000, k=1..8) with out_ready toggling 1,0,0,1,... -> outputs in order k<<24, none lost or duplicated. in_ready=0 whenever out_valid=1 and out_ready=0. Outputs stable during stall.
5. Lane independence: four lanes with distinct operands, one of them overflowing -> only that lane's ovf bit set; the other three lanes are exact.
6. Reset mid-flight: accept 2 transactions, assert rst for 1 cycle at cycle 2 -> out_valid stays 0, out_data=0, out_ovf=0 afterward; in_ready=1 the cycle after rst deasserts.
